// File: rtl/timing_pkg.sv
// -----------------------------------------------------------------------------
// timing_pkg
// Shared types and constants for the machine-cycle / beat timing generator.
//   state_e   : controller state (halted or running beats)
//   W1..W3    : one-hot machine-cycle codes
//   T1..T3    : one-hot beat codes
//   MCNT_W    : width of the completed-machine-cycle counter
//   next_w()  : machine-cycle sequencing rule applied at the last beat
// -----------------------------------------------------------------------------
package timing_pkg;

  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int MCNT_W = 8;

  localparam logic [2:0] W1 = 3'b001;
  localparam logic [2:0] W2 = 3'b010;
  localparam logic [2:0] W3 = 3'b100;

  localparam logic [2:0] T1 = 3'b001;
  localparam logic [2:0] T2 = 3'b010;
  localparam logic [2:0] T3 = 3'b100;

  // Next machine cycle, priority order: W1&SHORT, W1, W2&LONG, W2, W3.
  // SHORT only matters in W1 and LONG only in W2; any non-one-hot code
  // falls back to W1 so W can never leave the one-hot set.
  function automatic logic [2:0] next_w(input logic [2:0] w_cur,
                                        input logic       short_s,
                                        input logic       long_s);
    logic [2:0] w_nxt;
    case (w_cur)
      W1:      w_nxt = short_s ? W1 : W2;
      W2:      w_nxt = long_s  ? W3 : W1;
      W3:      w_nxt = W1;
      default: w_nxt = W1;
    endcase
    return w_nxt;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// -----------------------------------------------------------------------------
// edge_detect
// Rising-edge detector for a level input that is already synchronous to CLK.
// Ports:
//   CLK  : clock, rising-edge active
//   CLR  : synchronous active-low clear (history bit forced to 0)
//   d    : level input
//   rise : d & ~d_delayed; high for the cycle in which d first reads 1
// Because the history bit clears to 0, a d held high across clear release
// reports a rise on the first edge after release.
// -----------------------------------------------------------------------------
module edge_detect (
  input  logic CLK,
  input  logic CLR,
  input  logic d,
  output logic rise
);

  logic d_r;

  // One-cycle history of d.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      d_r <= 1'b0;
    end else begin
      d_r <= d;
    end
  end

  assign rise = d & ~d_r;

endmodule

// File: rtl/timing_gen.sv
// -----------------------------------------------------------------------------
// timing_gen
// Machine-cycle (W) and beat (T) timing generator for a hardwired controller.
// A start push-button edge moves the block from HALT to RUN; in RUN the beat
// rotates T1->T2->T3 and at T3 the next machine cycle is chosen from the
// controller hints SHORT/LONG, the cycle counter advances and STOP may halt.
// Ports:
//   CLK   : clock, rising-edge active
//   CLR   : synchronous active-low clear
//   QD    : start push-button level (active-high)
//   SHORT : finish instruction after W1 (sampled at T3 only)
//   LONG  : extend instruction into W3 (sampled at T3 only)
//   STOP  : halt at the end of the current machine cycle (sampled at T3)
//   W     : one-hot machine cycle, always one-hot
//   T     : one-hot beat, zero while halted
//   RUN   : 1 while beats advance
//   MCNT  : completed machine cycles, wraps modulo 256
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module timing_gen
  import timing_pkg::*;
(
  input  logic              CLK,
  input  logic              CLR,
  input  logic              QD,
  input  logic              SHORT,
  input  logic              LONG,
  input  logic              STOP,
  output logic [3:1]        W,
  output logic [3:1]        T,
  output logic              RUN,
  output logic [MCNT_W-1:0] MCNT
);

  state_e              state_r;
  state_e              state_s;
  logic [2:0]          w_r;
  logic [2:0]          w_s;
  logic [2:0]          t_r;
  logic [2:0]          t_s;
  logic                run_r;
  logic                run_s;
  logic [MCNT_W-1:0]   mcnt_r;
  logic [MCNT_W-1:0]   mcnt_s;
  logic                qd_rise_s;

  edge_detect u_qd_edge (
    .CLK  (CLK),
    .CLR  (CLR),
    .d    (QD),
    .rise (qd_rise_s)
  );

  // Next-state and next-output logic; everything defaults to "hold".
  always_comb begin
    state_s = state_r;
    w_s     = w_r;
    t_s     = t_r;
    run_s   = run_r;
    mcnt_s  = mcnt_r;
    case (state_r)
      ST_HALT: begin
        if (qd_rise_s) begin
          state_s = ST_RUN;
          t_s     = T1;
          run_s   = 1'b1;
        end else begin
          state_s = ST_HALT;
          t_s     = 3'b000;
          run_s   = 1'b0;
        end
      end
      ST_RUN: begin
        // A button edge while running is deliberately ignored.
        run_s = 1'b1;
        case (t_r)
          T1: t_s = T2;
          T2: t_s = T3;
          T3: begin
            // Controller hints are only meaningful on the last beat.
            w_s    = next_w(w_r, SHORT, LONG);
            mcnt_s = mcnt_r + MCNT_W'(1);
            if (STOP) begin
              state_s = ST_HALT;
              t_s     = 3'b000;
              run_s   = 1'b0;
            end else begin
              t_s     = T1;
            end
          end
          // A corrupted beat code restarts the machine cycle at T1.
          default: t_s = T1;
        endcase
      end
      default: begin
        state_s = ST_HALT;
        t_s     = 3'b000;
        run_s   = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared synchronously.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_r <= ST_HALT;
      w_r     <= W1;
      t_r     <= 3'b000;
      run_r   <= 1'b0;
      mcnt_r  <= '0;
    end else begin
      state_r <= state_s;
      w_r     <= w_s;
      t_r     <= t_s;
      run_r   <= run_s;
      mcnt_r  <= mcnt_s;
    end
  end

  assign W    = w_r;
  assign T    = t_r;
  assign RUN  = run_r;
  assign MCNT = mcnt_r;

endmodule

// File: doc/timing_gen.md
TIMING_GEN -- requirements
Module: timing_gen

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is synchronous and active-low.
REQ-002 The block SHALL have the port CLK (input, 1 bit): system clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port CLR (input, 1 bit): synchronous active-low clear.
REQ-004 The block SHALL have the port QD (input, 1 bit): start push-button, level, active-high, synchronous to CLK.
REQ-005 The block SHALL have the port SHORT (input, 1 bit): from the hardwired controller; end the instruction after W1.
REQ-006 The block SHALL have the port LONG (input, 1 bit): from the controller; extend the instruction into W3.
REQ-007 The block SHALL have the port STOP (input, 1 bit): from the controller; halt at the end of the current machine cycle.
REQ-008 The block SHALL have the port W (output, 3 bits, [3:1]): one-hot machine-cycle indicator.
REQ-009 The block SHALL have the port T (output, 3 bits, [3:1]): one-hot beat indicator; all-zero while halted.
REQ-010 The block SHALL have the port RUN (output, 1 bit): 1 while beats advance.
REQ-011 The block SHALL have the port MCNT (output, 8 bits): count of completed machine cycles.

Function
REQ-012 The block SHALL use two states: HALT and RUN.
REQ-013 In HALT, the block SHALL drive T=000 and RUN=0, and SHALL hold W and MCNT.
REQ-014 The block SHALL register QD (qd_d) and form qd_rise = QD & ~qd_d.
REQ-015 In HALT, qd_rise SHALL move the block to RUN with T=001 on the next cycle.
REQ-016 In RUN, the block SHALL ignore qd_rise.
REQ-017 In RUN, T SHALL rotate 001->010->100->001, one step per CLK.
REQ-018 SHORT, LONG and STOP SHALL be sampled only on the cycle where T=100; their values at other beats SHALL be ignored.
REQ-019 At T=100, the next W SHALL be chosen as follows, evaluated in this order:
- W1 & SHORT -> W1
- W1 -> W2
- W2 & LONG -> W3
- W2 -> W1
- W3 -> W1
REQ-020 At T=100, MCNT SHALL increment by 1, modulo 256 (255 -> 0).
REQ-021 At T=100 with STOP=1, W and MCNT SHALL update per REQ-019 and REQ-020, and the next state SHALL be HALT with T=000.
REQ-022 STOP SHALL take effect together with SHORT or LONG: W advances per REQ-019, then the block halts.
REQ-023 LONG sampled in W1 or W3 SHALL have no effect, and SHORT sampled in W2 or W3 SHALL have no effect.
REQ-024 Outputs SHALL be registered directly; there is no combinational path from inputs to outputs.
REQ-025 W SHALL always be exactly one-hot.
REQ-026 T SHALL be one-hot in RUN and zero in HALT.

Reset
REQ-027 When CLR=0 at a CLK edge, the next state SHALL be: HALT, W=001, T=000, RUN=0, MCNT=0, qd_d=0.
REQ-028 Reset SHALL override all other inputs, including mid-beat or mid-instruction; no partial machine cycle resumes afterward.
REQ-029 Because qd_d clears to 0 on reset, a QD held high through reset release SHALL produce qd_rise on the first clock edge after release (taking effect per REQ-015).

Structure
REQ-030 The package timing_pkg SHALL hold:
- state enum {HALT, RUN}
- one-hot constants W1/W2/W3 and T1/T2/T3
- MCNT width parameter (8)
REQ-031 The QD rising-edge detection SHALL be a sub-module edge_detect (ports CLK, CLR, d, rise).
REQ-032 All remaining logic SHALL be in timing_gen.

Verification
REQ-033 Reset then QD pulse, all controls 0 -> T sequence 001,010,100 repeats; W alternates 001,010,001; MCNT increments at each T=100.
REQ-034 SHORT=1 held in W1 -> W stays 001 across consecutive T=100 edges; MCNT +1 per three clocks.
REQ-035 LONG=1 asserted only at T=100 of W2 -> W goes 010->100->001; LONG asserted at T=010 only -> W2->W1.
REQ-036 STOP=1 at T=100 of W2 with LONG=1 -> W=100, T=000, RUN=0; QD held high stays halted until it drops and rises again, then resumes in W3 at T=001.
REQ-037 Preload MCNT to 255 by running 255 cycles, then one more T=100 -> MCNT=0.
REQ-038 CLR=0 at T=010 of W3 -> next cycle HALT, W=001, T=000, MCNT=0.
